// File: rtl/ysyx_22051013_regfile_sb_if.sv
// Bus bundle between the core pipeline and the scoreboarded register file:
// read ports, two write ports, pending-bit control and the pending count.
interface ysyx_22051013_regfile_sb_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG),
  parameter int unsigned NRD  = 2
);
  logic [NRD*AW-1:0]   raddr;
  logic [NRD-1:0]      ren;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                wen0;
  logic [AW-1:0]       waddr0;
  logic [XLEN-1:0]     wdata0;
  logic                wen1;
  logic [AW-1:0]       waddr1;
  logic [XLEN-1:0]     wdata1;
  logic                set_en;
  logic [AW-1:0]       set_addr;
  logic                flush;
  logic [AW:0]         pend_cnt;

  modport master (
    output raddr, ren, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
           set_en, set_addr, flush,
    input  rdata, rbusy, pend_cnt
  );

  modport slave (
    input  raddr, ren, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
           set_en, set_addr, flush,
    output rdata, rbusy, pend_cnt
  );
endinterface

// File: rtl/ysyx_22051013_regfile_sb.sv
// Multi-port register file with per-register pending bits and two write ports.
// Define YSYX_22051013_REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module ysyx_22051013_regfile_sb #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG),
  parameter int unsigned NRD  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22051013_regfile_sb_if.slave bus
);

  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_nxt;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_nxt;

  logic w0_act;
  logic w1_act;

  assign w0_act = bus.wen0 && (bus.waddr0 != '0);
  assign w1_act = bus.wen1 && (bus.waddr1 != '0);

  // Register array; port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (w0_act) regs[bus.waddr0] <= bus.wdata0;
      if (w1_act) regs[bus.waddr1] <= bus.wdata1;
    end
  end

  // Pending update: flush dominates, a set beats a same-cycle retire clear.
  always_comb begin
    pend_nxt = pend_q;
    if (w0_act) pend_nxt[bus.waddr0] = 1'b0;
    if (w1_act) pend_nxt[bus.waddr1] = 1'b0;
    if (bus.set_en) pend_nxt[bus.set_addr] = 1'b1;
    if (bus.flush) pend_nxt = '0;
    pend_nxt[0] = 1'b0;
  end

  // Count is recomputed from the bits every cycle rather than tracked.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  assign bus.pend_cnt = cnt_q;

  // Zero-latency read ports with optional write forwarding.
  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      a = bus.raddr[k*AW +: AW];
      d = regs[a];
      b = pend_q[a];
`ifdef YSYX_22051013_REGFILE_BYPASS_EN
      if (w0_act && (bus.waddr0 == a)) begin
        d = bus.wdata0;
        b = 1'b0;
      end
      if (w1_act && (bus.waddr1 == a)) begin
        d = bus.wdata1;
        b = 1'b0;
      end
`endif
      if (rst || !bus.ren[k] || (a == '0)) d = '0;
      bus.rdata[k*XLEN +: XLEN] = d;
      bus.rbusy[k]              = b && bus.ren[k] && !rst;
    end
  end

endmodule

// File: doc/ysyx_22051013_regfile_sb.md
# ysyx_22051013_regfile_sb

Parametrised multi-port integer register file with a per-register pending (scoreboard) bit, two write ports, and an optional write-to-read bypass. It sits between decode and writeback in the pipelined core. It replaces the fixed 2-read/1-write file. Decode uses the busy outputs to stall; writeback uses the two write ports to retire up to two results per cycle.

## Interface
Parameters:
- XLEN, 64, register width in bits
- NREG, 32, number of architectural registers; power of two, ≥ 2
- AW, $clog2(NREG), register address width
- NRD, 2, number of read ports, 1..4

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- raddr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW]
- ren  in  NRD  per-port read enable
- rdata  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN]
- rbusy  out  NRD  port k addresses a register with its pending bit set
- wen0 / waddr0 / wdata0  in  1 / AW / XLEN  write port 0
- wen1 / waddr1 / wdata1  in  1 / AW / XLEN  write port 1; higher priority than port 0
- set_en / set_addr  in  1 / AW  mark the destination of an issued instruction pending
- flush  in  1  clear all pending bits (pipeline squash)
- pend_cnt  out  AW+1  registered count of set pending bits

## Operation
- Storage: NREG×XLEN registers plus NREG pending bits. Register 0 reads as 0. Writes to register 0 are dropped, and its pending bit never sets.
- Write: when wenN=1 and waddrN≠0, regs[waddrN]←wdataN at the clock edge. When both ports target the same address, port 1's data is stored.
- Pending-bit update per cycle, in priority order:
  - rst clears all bits.
  - flush clears all bits; set_en is ignored that cycle.
  - set_en sets bit set_addr, including when the same address is being cleared that cycle.
  - wenN clears bit waddrN.
- pend_cnt is a register holding the popcount of the pending bits after the update. It is not an incrementer, so it cannot drift.
- Read (combinational):
  - rdata port k = 0 when rst=1, ren[k]=0 or raddr=0.
  - Otherwise it is the register contents, subject to bypass (see Configuration).
- rbusy[k] = pending[raddr_k] & ren[k] & ~rst.
  - With bypass enabled, a same-cycle write to that address masks rbusy.
  - Any set_en in the same cycle does not affect rbusy until the next cycle.

## Timing
- Writes become visible in the register array one cycle after the edge on which they are presented.
- Pending set/clear takes effect on the edge; rbusy and pend_cnt reflect it in the following cycle.
- Read path has zero-cycle latency. There is no handshake; the consumer samples rdata/rbusy in the same cycle.
- Reset values: all registers 0, all pending bits 0, pend_cnt 0, rdata 0, rbusy 0.
- Reset mid-operation: any write or set presented with rst=1 is discarded.
- Simultaneous set on address A and write to A in the same cycle: the data is written and A remains pending. The set belongs to the younger producer.

## Configuration
- YSYX_22051013_REGFILE_BYPASS_EN defined:
  - A read whose address matches an active write this cycle returns that write data; port 1 wins over port 0.
  - rbusy for that port is forced 0.
- Not defined:
  - Reads return the stored array value only.
  - rbusy reflects the pending bit regardless of same-cycle writes; the new value appears the next cycle.

## Test plan
- Reset, then read all NREG addresses on every port.
  - Required: rdata=0, rbusy=0, pend_cnt=0.
- wen0=1, waddr0=5, wdata0=0x1122334455667788.
  - Next cycle raddr=5 reads 0x1122334455667788.
  - A write to reg 0 of 0xFFFF leaves reg 0 reading 0.
- Both ports write addr 9 in the same cycle (port 0 = 0xAA, port 1 = 0xBB).
  - Required: next-cycle read = 0xBB.
- set_en addr 3, next cycle read 3 → rbusy=1, pend_cnt=1. Then wen1 addr 3 data 0x7 with raddr=3 in that cycle:
  - BYPASS_EN: rdata=0x7, rbusy=0.
  - Without the macro: rdata=old value, rbusy=1.
  - Both: the following cycle has rbusy=0, pend_cnt=0.
- set_en on addrs 1, 2, 4 in consecutive cycles → pend_cnt=3. Then flush together with set_en addr 6:
  - Required: next cycle pend_cnt=0, all rbusy=0.
- Set pending on addr 8, then assert rst for one cycle with wen0 to addr 8 (data 0x55).
  - Required: after reset, reg 8 = 0, not pending, pend_cnt=0.
